// File: rtl/bcd_ex3_seq.sv
// Multi-digit BCD -> Excess-3 sequencer: one shared digit converter, one digit per clock,
// LSD first, with valid/ready handshakes on both the input word and the result words.
module bcd_ex3_seq #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned IDXW   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_ex3,
  output logic [4*DIGITS-1:0]   out_nine,
  output logic [4*DIGITS-1:0]   out_ex3_comp,
  output logic [DIGITS-1:0]     out_err,
  output logic                  busy
);

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e                state_q, state_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0]   word_q, word_d;
  logic [4*DIGITS-1:0]   ex3_q, ex3_d;
  logic [4*DIGITS-1:0]   nine_q, nine_d;
  logic [4*DIGITS-1:0]   comp_q, comp_d;
  logic [DIGITS-1:0]     err_q, err_d;

  logic [3:0] cur_digit;
  logic [3:0] dig_ex3, dig_nine, dig_comp;
  logic       dig_err;

  // Digit mux over the captured word
  always_comb begin
    cur_digit = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (idx_q == IDXW'(k)) cur_digit = word_q[4*k +: 4];
    end
  end

  // Shared converter; non-decimal codes map to fixed patterns, never wrapped arithmetic
  always_comb begin
    if (cur_digit <= 4'd9) begin
      dig_ex3  = cur_digit + 4'd3;
      dig_nine = 4'd9 - cur_digit;
      dig_comp = ~(cur_digit + 4'd3);
      dig_err  = 1'b0;
    end else begin
      dig_ex3  = 4'h0;
      dig_nine = 4'h0;
      dig_comp = 4'hF;
      dig_err  = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    ex3_d   = ex3_q;
    nine_d  = nine_q;
    comp_d  = comp_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          word_d  = in_bcd;
          ex3_d   = '0;
          nine_d  = '0;
          comp_d  = '0;
          err_d   = '0;
          idx_d   = '0;
          state_d = StConv;
        end
      end
      StConv: begin
        for (int unsigned k = 0; k < DIGITS; k++) begin
          if (idx_q == IDXW'(k)) begin
            ex3_d[4*k +: 4]  = dig_ex3;
            nine_d[4*k +: 4] = dig_nine;
            comp_d[4*k +: 4] = dig_comp;
            err_d[k]         = dig_err;
          end
        end
        if (idx_q == IDXW'(DIGITS - 1)) state_d = StDone;
        else                            idx_d   = idx_q + 1'b1;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      word_q  <= '0;
      ex3_q   <= '0;
      nine_q  <= '0;
      comp_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      ex3_q   <= ex3_d;
      nine_q  <= nine_d;
      comp_q  <= comp_d;
      err_q   <= err_d;
    end
  end

  assign in_ready     = (state_q == StIdle);
  assign out_valid    = (state_q == StDone);
  assign busy         = (state_q != StIdle);
  assign out_ex3      = ex3_q;
  assign out_nine     = nine_q;
  assign out_ex3_comp = comp_q;
  assign out_err      = err_q;

endmodule

// File: doc/bcd_ex3_seq.md
Name: bcd_ex3_seq

Overview:
- Multi-digit sequencer for BCD -> Excess-3 conversion.
- Accepts a packed DIGITS-wide BCD word over a valid/ready handshake.
- Time-shares one 4-bit digit converter across all digits, one digit per clock, LSD first.
- Returns packed Excess-3, 9's complement, complemented Excess-3 and per-digit invalid flags over a second valid/ready handshake; sits between the decimal input front-end and the display/arithmetic consumers.

Parameters:
- DIGITS, 4, number of BCD digits per word (1..16).
- IDXW, 4, width of internal digit index; must satisfy 2^IDXW >= DIGITS.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_bcd presented.
- in_ready  out  1  block can accept a word.
- in_bcd  in  4*DIGITS  packed BCD; digit k at [4k+3:4k].
- out_valid  out  1  result words valid.
- out_ready  in  1  consumer accepts result.
- out_ex3  out  4*DIGITS  per digit: d+3.
- out_nine  out  4*DIGITS  per digit: 9-d.
- out_ex3_comp  out  4*DIGITS  per digit: bitwise NOT of out_ex3 digit.
- out_err  out  DIGITS  bit k set when input digit k > 9.
- busy  out  1  high in CONV or DONE.

Behaviour:
- Clock/reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, idx=0, in_ready=1, out_valid=0, busy=0, out_ex3/out_nine/out_ex3_comp/out_err = all zeros, captured word = 0.
- FSM states: IDLE, CONV, DONE.
  - IDLE: in_ready=1. On in_valid&in_ready, capture in_bcd, clear all out_* registers to 0, idx<=0, go to CONV. Otherwise stay.
  - CONV: in_ready=0. Each cycle, convert captured digit idx and write the result into digit slot idx of all out_* registers.
    - If idx==DIGITS-1, go to DONE; else idx<=idx+1.
  - DONE: out_valid=1, in_ready=0. On out_valid&out_ready, go to IDLE, out_valid<=0. While out_ready=0, all outputs are held bit-stable.
- Digit conversion, d = 4-bit digit:
  - d in 0..9: ex3=d+3 (4-bit), nine=9-d, comp=~(d+3), err=0.
  - d in 10..15: ex3=0000, nine=0000, comp=1111, err=1. No wrap-around arithmetic is ever output.
- Latency:
  - Accept at edge E0; conversion occupies DIGITS cycles; out_valid is first high after edge E0+DIGITS.
  - DIGITS=1: out_valid high the cycle after CONV's single cycle.
- Throughput:
  - in_ready is low from accept until the result handshake completes; no input is accepted in CONV or DONE (in_valid there is ignored, in_bcd not sampled).
  - Minimum period is DIGITS+2 cycles per word (accept, DIGITS conversions, output handshake, return to IDLE).
  - in_ready is combinationally (state==IDLE) and does not depend on out_ready.
- Index bound: idx never exceeds DIGITS-1.
- Reset mid-operation: rst in any state forces the reset values on the next edge; the partial result is discarded and out_valid does not pulse.
- Simultaneous rst and in_valid: reset wins; the word is not captured.
- Output contents are defined only while out_valid=1; during CONV, partially written digits may be visible.

Test Plan (DIGITS=4):
- Reset, then in_bcd=16'h1234 with in_valid pulse -> out_valid after 4 CONV cycles with out_ex3=16'h4567, out_nine=16'h8765, out_ex3_comp=16'hBA98, out_err=4'b0000.
- in_bcd=16'h9A05 -> out_ex3=16'hC038, out_nine=16'h0094, out_ex3_comp=16'h3FC7, out_err=4'b0100.
- in_bcd=16'h0949 (exercises digit 4) -> out_ex3=16'h3C7C, out_nine=16'h9050, out_ex3_comp=16'hC383, out_err=0.
- Backpressure: result ready, out_ready low 5 cycles -> out_valid stays 1, all outputs stable, in_ready=0; in_valid with 16'h5555 during that time is ignored. out_ready high -> IDLE next cycle.
- Back-to-back: in_valid held high, out_ready held high, words 16'h0000 then 16'h9999 -> results 16'h3333 then 16'hCCCC, with accepts spaced exactly 6 cycles apart.
- rst asserted on the 2nd CONV cycle -> next cycle IDLE, in_ready=1, out_valid=0, all outputs zero; a new word 16'h8888 then converts to out_ex3=16'hBBBB.
